cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
//  Sits directly below the 5-stage CPU core and consumes its instruction-fetch and data-access requests.
//  - Both requests use the sram-like req/addr_ok/data_ok handshake.
//  - It merges them onto one downstream sram-like bus: the memory port or the future AXI bridge.
//  - Arbitration is fixed-priority, with data before inst.
//  - Responses come back in order and are routed to their source using a tag FIFO of outstanding requests.
// PARAMETERS
//  MAX_OUT  2  max accepted-but-unanswered downstream transactions (tag FIFO depth, >=1)
//  CNT_W    2  width of outstanding counter, >= clog2(MAX_OUT+1)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high
//  inst_req      in   1   fetch request valid (read only)
//  inst_addr     in   32  fetch physical address
//  inst_addr_ok  out  1   fetch address accepted this cycle
//  inst_data_ok  out  1   fetch data returned this cycle
//  inst_rdata    out  32  fetch data, valid when inst_data_ok
//  data_req      in   1   load/store request valid
//  data_wr       in   1   1 = store, 0 = load
//  data_wstrb    in   4   store byte enables
//  data_addr     in   32  load/store physical address
//  data_wdata    in   32  store data
//  data_addr_ok  out  1   load/store address accepted this cycle
//  data_data_ok  out  1   load data returned / store acknowledged
//  data_rdata    out  32  load data, valid when data_data_ok
//  mem_req       out  1   downstream request valid
//  mem_wr        out  1   downstream write
//  mem_wstrb     out  4   downstream byte enables (0 for reads)
//  mem_addr      out  32  downstream address
//  mem_wdata     out  32  downstream write data
//  mem_addr_ok   in   1   downstream accepted address (handshake = mem_req & mem_addr_ok)
//  mem_data_ok   in   1   downstream response, strictly in acceptance order
//  mem_rdata     in   32  downstream read data
// BEHAVIOUR
//  - Reset: tag FIFO empty (count=0, rd/wr ptr=0), grant lock cleared.
//    During the reset cycle, mem_req, both *_addr_ok and both *_data_ok are 0.
//  - Grant:
//    - If lock is clear, grant = data when data_req, else inst when inst_req.
//    - mem_req = granted request valid & (count < MAX_OUT).
//    - When mem_req=1 and mem_addr_ok=0, lock the grant (register src).
//      Keep the locked src until the handshake, even if the other source requests.
//      The mem_* fields mirror the locked source and must stay stable.
//    - The lock clears on the handshake cycle.
//  - Field routing:
//    - For inst, mem_wr=0 and mem_wstrb=0.
//    - For data loads, mem_wstrb is forced to 0.
//  - Address handshake: {inst,data}_addr_ok = mem_req & mem_addr_ok & (grant == that source), combinational.
//  - Tag FIFO:
//    - On a handshake, push src (0=inst, 1=data).
//    - On mem_data_ok with count>0, pop the head.
//    - head=0 asserts inst_data_ok; head=1 asserts data_data_ok.
//    - Both outputs are combinational in the mem_data_ok cycle.
//  - Read data: inst_rdata = data_rdata = mem_rdata (unregistered pass-through).
//  - Zero-latency path: push and pop in the same cycle is legal.
//    The popped entry is the old head; count is unchanged.
//  - Full: when count == MAX_OUT, mem_req is held 0, even if a pop occurs in the same cycle.
//    The request re-issues the next cycle.
//  - Empty: mem_data_ok with count=0 is a protocol error.
//    Ignore it: no *_data_ok, no state change. Flag it with a simulation-only assertion.
//  - Pointers wrap modulo MAX_OUT. Count never exceeds MAX_OUT and never goes negative.
//  - Reset mid-transaction: all outstanding tags are discarded.
//    The downstream slave must be reset in the same cycle.
//  - Requests are not reordered: a younger response can never overtake an older one.
// STRUCTURE
//  - Tag FIFO as sub-module tag_fifo (WIDTH=1, DEPTH=MAX_OUT) with push/pop/full/empty/head.
//  - Shared package constants: SRC_INST=1'b0, SRC_DATA=1'b1.
//  - Grant/lock logic and muxes stay in the top of this file.
// TESTING
//  1. Single fetch: inst_req=1, inst_addr=0xBFC00000, slave addr_ok same cycle, data_ok +1 with 0x3C1D0001.
//     -> inst_addr_ok at t0; inst_data_ok=1 with rdata 0x3C1D0001 at t1; count back to 0.
//  2. Simultaneous requests: inst_req & data_req (load 0x80000010) in the same cycle.
//     -> data granted first; inst accepted next cycle; responses route data then inst.
//  3. Lock: data store 0x80000020 wstrb=4'b0011 wdata=0xDEADBEEF, slave holds addr_ok=0 for 3 cycles while inst_req rises.
//     -> mem_addr/wdata/wstrb stable for 4 cycles; inst waits until after the store handshake.
//  4. Full: MAX_OUT=2, slave withholds data_ok; issue 3 fetches.
//     -> third mem_req=0 until first data_ok; then third issues; 3 inst_data_ok in order.
//  5. Zero-latency: same-cycle addr_ok/data_ok streaming of 8 fetches at count=1.
//     -> one inst_data_ok per cycle; count stays 1.
//  6. Reset with 2 outstanding, then a spurious mem_data_ok after reset.
//     -> count=0, no *_data_ok asserted, all outputs 0 during reset.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared constants and types for the CPU-side memory arbiter.
// The source encoding is also the value stored in the outstanding-tag FIFO.
package cpu_mem_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // A grant either follows the current priority pick, or is frozen on the
    // source whose request is still waiting for the downstream slave to accept it.
    typedef enum logic {
        GRANT_OPEN   = 1'b0,
        GRANT_LOCKED = 1'b1
    } grantState_e;

    // Byte enables only travel downstream for data stores.
    // Fetches and loads present an all-zero strobe.
    function automatic logic [3:0] busStrobe(input logic isData,
                                             input logic isWrite,
                                             input logic [3:0] wstrb);
        return (isData && isWrite) ? wstrb : 4'b0000;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_tag_fifo.sv
// Small FIFO that records the source of every accepted downstream request.
// Responses return in acceptance order, so the head always names the owner of
// the next response.
module cpu_mem_arbiter_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];

    // A push into a full FIFO or a pop from an empty one is dropped, so the
    // count can never leave the range 0..DEPTH.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Next pointers wrap explicitly so non-power-of-two depths also work.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
        end
        if (doPush) begin
            wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy and pointers; a reset drops every outstanding tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Tag storage needs no reset, because only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges the CPU instruction-fetch and data-access sram-like ports onto a
// single downstream sram-like bus. Data has priority over inst. A stalled
// grant is locked until the slave accepts it. Responses are steered back to
// their source using the in-order tag FIFO.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    grantState_e grantState_q;
    logic        lockSrc_q;
    logic        grantSrc;
    logic        grantValid;
    logic        grantIsData;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        fifoHead;
    logic        handshake;
    logic        popValid;

    // While locked, the frozen source keeps the bus. Otherwise data wins over inst.
    always_comb begin
        grantSrc   = SRC_INST;
        grantValid = 1'b0;
        if (grantState_q == GRANT_LOCKED) begin
            grantSrc   = lockSrc_q;
            grantValid = (lockSrc_q == SRC_DATA) ? data_req : inst_req;
        end else if (data_req) begin
            grantSrc   = SRC_DATA;
            grantValid = 1'b1;
        end else if (inst_req) begin
            grantSrc   = SRC_INST;
            grantValid = 1'b1;
        end
    end

    assign grantIsData = (grantSrc == SRC_DATA);

    // A full tag FIFO blocks new requests even if a response pops in the same
    // cycle. Reset masks every strobe while state is being cleared.
    assign mem_req   = grantValid && !fifoFull && !reset;
    assign handshake = mem_req && mem_addr_ok;

    assign mem_wr    = grantIsData && data_wr;
    assign mem_wstrb = busStrobe(grantIsData, data_wr, data_wstrb);
    assign mem_addr  = grantIsData ? data_addr : inst_addr;
    assign mem_wdata = grantIsData ? data_wdata : 32'h0000_0000;

    assign inst_addr_ok = handshake && (grantSrc == SRC_INST);
    assign data_addr_ok = handshake && (grantSrc == SRC_DATA);

    // A response with nothing outstanding is ignored rather than routed.
    assign popValid     = mem_data_ok && !fifoEmpty && !reset;
    assign inst_data_ok = popValid && (fifoHead == SRC_INST);
    assign data_data_ok = popValid && (fifoHead == SRC_DATA);

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // Grant lock: freeze the source when the slave stalls, release on the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            grantState_q <= GRANT_OPEN;
            lockSrc_q    <= SRC_INST;
        end else begin
            case (grantState_q)
                GRANT_OPEN: begin
                    if (mem_req && !mem_addr_ok) begin
                        grantState_q <= GRANT_LOCKED;
                        lockSrc_q    <= grantSrc;
                    end
                end
                GRANT_LOCKED: begin
                    if (handshake) begin
                        grantState_q <= GRANT_OPEN;
                    end
                end
                default: grantState_q <= GRANT_OPEN;
            endcase
        end
    end

    cpu_mem_arbiter_tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_tagFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (handshake),
        .pop_i   (popValid),
        .din_i   (grantSrc),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Flag a downstream response that arrives with no request outstanding.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_data_ok && fifoEmpty))
                else $warning("cpu_mem_arbiter: mem_data_ok with no outstanding request ignored");
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomised and directed bench for cpu_mem_arbiter. It checks the arbiter
// against a transaction-level model: a queue of outstanding owners, one queue
// of expected addresses per source, and a slave whose read data is a fixed
// function of the address.
module tb_cpu_mem_arbiter;

    localparam int          MAX_OUT = 2;
    localparam logic [31:0] KEY     = 32'h83DD_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    // Environment knobs and model state.
    int          addrOkProb = 100;
    int          dataOkProb = 100;
    bit          spurious = 1'b0;
    bit          modelLocked = 1'b0;
    bit          modelLockSrc = 1'b0;
    bit          ownerQ[$];
    logic [31:0] instExp[$];
    logic [31:0] dataExp[$];
    logic [31:0] slaveQ[$];
    bit          instAcc = 1'b0, dataAcc = 1'b0;
    bit          prevStall = 1'b0;
    logic [31:0] prevAddr, prevWdata;
    logic [3:0]  prevWstrb;
    int          hsCount = 0;
    int          instOkCount = 0;

    cpu_mem_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One bus cycle, entered at a negedge: the slave drives its side, outputs
    // settle and are checked against the model, then the model advances.
    task automatic applyStimulus();
        bit gv, gs, expReq, expHs, expPop, expHead;
        mem_addr_ok = ($urandom_range(99) < addrOkProb);
        mem_data_ok = spurious || (slaveQ.size() > 0 && $urandom_range(99) < dataOkProb);
        mem_rdata   = (slaveQ.size() > 0) ? (slaveQ[0] ^ KEY) : $urandom();
        #1;
        gv = 1'b0;
        gs = 1'b0;
        if (modelLocked) begin
            gs = modelLockSrc;
            gv = gs ? data_req : inst_req;
        end else if (data_req) begin
            gv = 1'b1;
            gs = 1'b1;
        end else if (inst_req) begin
            gv = 1'b1;
            gs = 1'b0;
        end
        expReq  = !reset && gv && (ownerQ.size() < MAX_OUT);
        expHs   = expReq && mem_addr_ok;
        expPop  = !reset && mem_data_ok && (ownerQ.size() > 0);
        expHead = (ownerQ.size() > 0) ? ownerQ[0] : 1'b0;

        checkOutput("mem_req", mem_req, expReq);
        checkOutput("inst_addr_ok", inst_addr_ok, expHs && !gs);
        checkOutput("data_addr_ok", data_addr_ok, expHs && gs);
        checkOutput("inst_data_ok", inst_data_ok, expPop && !expHead);
        checkOutput("data_data_ok", data_data_ok, expPop && expHead);
        if (expReq) begin
            checkOutput("mem_addr", mem_addr, gs ? data_addr : inst_addr);
            checkOutput("mem_wr", mem_wr, gs && data_wr);
            checkOutput("mem_wstrb", mem_wstrb, (gs && data_wr) ? data_wstrb : 4'b0000);
            if (gs && data_wr) checkOutput("mem_wdata", mem_wdata, data_wdata);
        end
        if (prevStall && !reset) begin
            checkOutput("stable_addr", mem_addr, prevAddr);
            checkOutput("stable_wdata", mem_wdata, prevWdata);
            checkOutput("stable_wstrb", mem_wstrb, prevWstrb);
        end
        if (expPop && !expHead && instExp.size() > 0) checkOutput("inst_rdata", inst_rdata, instExp.pop_front() ^ KEY);
        if (expPop && expHead && dataExp.size() > 0) checkOutput("data_rdata", data_rdata, dataExp.pop_front() ^ KEY);

        if (reset) begin
            ownerQ.delete();
            instExp.delete();
            dataExp.delete();
            slaveQ.delete();
            modelLocked = 1'b0;
            prevStall   = 1'b0;
        end else begin
            if (expPop) ownerQ.pop_front();
            if (mem_data_ok && slaveQ.size() > 0) void'(slaveQ.pop_front());
            if (expHs) begin
                ownerQ.push_back(gs);
                if (gs) dataExp.push_back(data_addr);
                else    instExp.push_back(inst_addr);
                slaveQ.push_back(mem_addr);
                hsCount++;
            end
            if (expReq && !mem_addr_ok) begin
                modelLocked  = 1'b1;
                modelLockSrc = gs;
            end else if (expHs) begin
                modelLocked = 1'b0;
            end
            prevStall = expReq && !mem_addr_ok;
        end
        prevAddr  = mem_addr;
        prevWdata = mem_wdata;
        prevWstrb = mem_wstrb;
        instAcc   = inst_addr_ok;
        dataAcc   = data_addr_ok;
        if (inst_data_ok) instOkCount++;
        @(negedge clk);
    endtask

    // Protocol-following masters: hold a request until accepted, then maybe start a new one.
    task automatic autoMasters(input int instProb, input int dataProb);
        if (!inst_req || instAcc) begin
            inst_req  = ($urandom_range(99) < instProb);
            inst_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!data_req || dataAcc) begin
            data_req   = ($urandom_range(99) < dataProb);
            data_wr    = 1'($urandom_range(1));
            data_wstrb = 4'($urandom_range(15));
            data_addr  = $urandom() & 32'hFFFF_FFFC;
            data_wdata = $urandom();
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            autoMasters(0, 0);
            applyStimulus();
        end
    endtask

    initial begin
        int hsStart, okStart, issued;
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        // Single fetch: accepted at once, answered on the following cycle.
        $display("[TB] single fetch");
        okStart = instOkCount;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        applyStimulus();
        checkOutput("fetch_t0_addr_ok", instAcc, 1'b1);
        autoMasters(0, 0);
        applyStimulus();
        checkOutput("fetch_t1_data_ok", instOkCount - okStart, 1);
        idleCycles(2);

        // Simultaneous requests: the data load goes first, then the fetch.
        $display("[TB] simultaneous requests");
        inst_req   = 1'b1;
        inst_addr  = 32'h0040_0100;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_wstrb = 4'hF;
        data_addr  = 32'h8000_0010;
        data_wdata = 32'h1234_5678;
        applyStimulus();
        checkOutput("simul_data_first", dataAcc, 1'b1);
        autoMasters(0, 0);
        applyStimulus();
        checkOutput("simul_inst_next", instAcc, 1'b1);
        idleCycles(3);

        // Lock: a stalled store keeps the bus while a fetch arrives behind it.
        $display("[TB] grant lock");
        addrOkProb = 0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h8000_0020;
        data_wdata = 32'hDEAD_BEEF;
        applyStimulus();
        inst_req  = 1'b1;
        inst_addr = 32'h0040_0200;
        applyStimulus();
        applyStimulus();
        addrOkProb = 100;
        applyStimulus();
        checkOutput("lock_store_hs", dataAcc, 1'b1);
        checkOutput("lock_inst_wait", instAcc, 1'b0);
        autoMasters(0, 0);
        applyStimulus();
        checkOutput("lock_inst_after", instAcc, 1'b1);
        idleCycles(3);

        // Full: with responses withheld only MAX_OUT fetches get through.
        $display("[TB] full");
        dataOkProb = 0;
        hsStart = hsCount;
        okStart = instOkCount;
        issued  = 0;
        for (int i = 0; i < 6; i++) begin
            if ((!inst_req || instAcc) && issued < 3) begin
                inst_req  = 1'b1;
                inst_addr = 32'h0040_1000 + 32'(issued * 4);
                issued++;
            end else begin
                autoMasters(0, 0);
            end
            applyStimulus();
        end
        checkOutput("full_hold", hsCount - hsStart, MAX_OUT);
        dataOkProb = 100;
        idleCycles(8);
        checkOutput("full_drain", instOkCount - okStart, 3);

        // Zero-latency streaming at one outstanding: accept and answer every cycle.
        $display("[TB] zero-latency stream");
        dataOkProb = 0;
        inst_req   = 1'b1;
        inst_addr  = 32'h0040_2000;
        applyStimulus();
        dataOkProb = 100;
        hsStart = hsCount;
        okStart = instOkCount;
        for (int i = 0; i < 8; i++) begin
            inst_req  = 1'b1;
            inst_addr = 32'h0040_2004 + 32'(i * 4);
            applyStimulus();
        end
        checkOutput("stream_accepts", hsCount - hsStart, 8);
        checkOutput("stream_responses", instOkCount - okStart, 8);
        idleCycles(3);

        // Reset with two outstanding, then a stray response afterwards.
        $display("[TB] reset mid-transaction");
        dataOkProb = 0;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_addr  = 32'h8000_0040;
        inst_req   = 1'b1;
        inst_addr  = 32'h0040_3000;
        applyStimulus();
        autoMasters(0, 0);
        applyStimulus();
        checkOutput("pre_reset_outstanding", ownerQ.size(), 2);
        inst_req = 1'b1;
        data_req = 1'b1;
        reset    = 1'b1;
        spurious = 1'b1;
        applyStimulus();
        reset    = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        okStart  = instOkCount;
        applyStimulus();
        spurious = 1'b0;
        checkOutput("spurious_ignored", instOkCount - okStart, 0);
        dataOkProb = 100;
        inst_req  = 1'b1;
        inst_addr = 32'h0040_4000;
        applyStimulus();
        idleCycles(2);

        // Randomised traffic with varying slave behaviour and occasional resets.
        $display("[TB] random traffic");
        for (int blk = 0; blk < 15; blk++) begin
            int ip, dp;
            addrOkProb = $urandom_range(100, 20);
            dataOkProb = $urandom_range(100, 20);
            ip = $urandom_range(100);
            dp = $urandom_range(100);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(299) == 0) reset = 1'b1;
                autoMasters(ip, dp);
                applyStimulus();
                reset = 1'b0;
            end
        end
        addrOkProb = 100;
        dataOkProb = 100;
        idleCycles(10);
        checkOutput("final_drained", ownerQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a stuck simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
